d_ffs_2stage: RTL and testbench



---
 rtl/d_ffs_2stage_pkg.sv | 11 +
 rtl/d_ffs_2stage_stage.sv | 21 ++
 rtl/d_ffs_2stage.sv | 50 +++++
 tb/tb_d_ffs_2stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/d_ffs_2stage_pkg.sv
// rtl/d_ffs_2stage_pkg.sv - shared constants and types for the registered delay line
package d_ffs_2stage_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 2;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    localparam data_t RESET_VAL = '0;

endpackage

// File: rtl/d_ffs_2stage_stage.sv
// rtl/d_ffs_2stage_stage.sv - one asynchronously cleared register bank
module d_ff_stage #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d every rising edge; clear immediately while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_ffs_2stage.sv
// rtl/d_ffs_2stage.sv - DEPTH-stage registered delay of a data word
module d_ffs_2stage
    import d_ffs_2stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Package reset word is all zeros; replicate one bit so any WIDTH works.
    localparam logic [WIDTH-1:0] STAGE_RESET = {WIDTH{RESET_VAL[0]}};

    // First-stage output, kept under this name for hierarchical debug probes.
    logic [WIDTH-1:0] n1;

    // Output of every stage; index 0 is the stage fed by a.
    logic [WIDTH-1:0] stage_q [DEPTH];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic [WIDTH-1:0] stage_d;

            if (k == 0) begin : g_head
                assign stage_d = a;
            end else begin : g_chain
                assign stage_d = stage_q[k-1];
            end

            d_ff_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (STAGE_RESET)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .d   (stage_d),
                .q   (stage_q[k])
            );
        end
    endgenerate

    // With DEPTH=1 both taps land on the same register.
    assign n1 = stage_q[0];
    assign y  = stage_q[DEPTH-1];

endmodule

// File: tb/tb_d_ffs_2stage.sv
// tb/tb_d_ffs_2stage.sv - randomized and directed checks of the two-stage delay
module tb_d_ffs_2stage;

    localparam int W = 4;
    localparam int D = 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] y;

    int vectors;
    int miscompares;
    bit check_en;

    // Words captured at each edge since the last reset (zero when captured in reset).
    logic [W-1:0] hist [$];

    d_ffs_2stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .y   (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] exp_n1();
        if (hist.size() >= 1) return hist[hist.size()-1];
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_y();
        if (hist.size() >= D) return hist[hist.size()-D];
        return '0;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reset wipes all in-flight words immediately.
    always @(posedge rst) hist.delete();

    // Reference: each edge records the sampled word, or zero if still in reset.
    always @(posedge clk) begin
        hist.push_back(rst ? '0 : a);
        if (hist.size() > D) void'(hist.pop_front());
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("model_n1", dut.n1, exp_n1());
            check("model_y", y, exp_y());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] svals [4];
        int gap;
        svals[0] = 4'd3; svals[1] = 4'd5; svals[2] = 4'd9; svals[3] = 4'd12;
        vectors = 0;
        miscompares = 0;
        check_en = 1'b0;

        // Reset: clears without any clock edge.
        rst = 1'b1;
        a = 4'hF;
        #1;
        check("reset_n1_immediate", dut.n1, 4'h0);
        check("reset_y_immediate", y, 4'h0);
        check_en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_hold_n1", dut.n1, 4'h0);
            check("reset_hold_y", y, 4'h0);
        end

        // Latency after release.
        @(negedge clk); #1;
        rst = 1'b0;
        a = 4'b1010;
        @(posedge clk); #1;
        check("lat_n1", dut.n1, 4'b1010);
        check("lat_y_before", y, 4'b0000);
        @(posedge clk); #1;
        check("lat_y_after", y, 4'b1010);

        // Streaming: one word per edge, y trails by one extra edge.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            a = svals[i];
            @(posedge clk); #1;
            if (i >= 1) check("stream_y", y, svals[i-1]);
        end
        @(posedge clk); #1;
        check("stream_y_last", y, svals[3]);

        // Inter-edge glitch must never be captured.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            a = 4'h6;
            #1 a = 4'hA;
            #1 a = 4'h6;
            @(posedge clk); #1;
            check("glitch_n1", dut.n1, 4'h6);
            if (i >= 1) check("glitch_y", y, 4'h6);
        end

        // Mid-stream reset discards in-flight words.
        @(negedge clk); #1; a = 4'h9;
        @(negedge clk); #1; a = 4'hC;
        @(posedge clk); #1;
        check("pre_rst_n1", dut.n1, 4'hC);
        check("pre_rst_y", y, 4'h9);
        #2 rst = 1'b1;
        #1;
        check("midrst_n1_clear", dut.n1, 4'h0);
        check("midrst_y_clear", y, 4'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        a = 4'h1;
        @(posedge clk); #1;
        check("post_rst_n1", dut.n1, 4'h1);
        check("post_rst_y_zero", y, 4'h0);
        @(posedge clk); #1;
        check("post_rst_y", y, 4'h1);

        // Random words with random spacing, never on an edge.
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(5, 15);
            #(gap);
            if (($time % 10) == 5) #1;
            a = W'($urandom);
        end
        repeat (4) @(posedge clk);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
